// File: rtl/gray_conv_sequencer.sv
// Frame sequencer that streams RGB pixels through an external gray converter,
// one pixel in flight, with a per-pixel completion timeout.
module gray_conv_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned LEN_W          = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             frame_go,
  input  logic [LEN_W-1:0] frame_pixels,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_rgb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_gray,
  output logic             conv_start,
  output logic [23:0]      conv_rgb,
  output logic             conv_clear,
  input  logic             conv_done,
  input  logic [7:0]       conv_gray,
  output logic             busy,
  output logic             frame_done,
  output logic [LEN_W-1:0] pix_count,
  output logic             timeout_err
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StPresent,
    StRecover
  } state_e;

  state_e              state_q;
  logic [LEN_W-1:0]    len_q;
  logic [TimerW-1:0]   timer_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= StIdle;
      len_q       <= '0;
      timer_q     <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_gray    <= '0;
      conv_start  <= 1'b0;
      conv_rgb    <= '0;
      conv_clear  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      pix_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      // Pulse outputs default low; converter clear only drops on entry to StRecover.
      conv_start <= 1'b0;
      frame_done <= 1'b0;
      conv_clear <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (frame_go) begin
            if (frame_pixels != '0) begin
              len_q       <= frame_pixels;
              pix_count   <= '0;
              timeout_err <= 1'b0;
              in_ready    <= 1'b1;
              busy        <= 1'b1;
              state_q     <= StFetch;
            end else begin
              frame_done <= 1'b1;
            end
          end
        end
        StFetch: begin
          if (in_valid) begin
            conv_rgb   <= in_rgb;
            in_ready   <= 1'b0;
            conv_start <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A completion on the final allowed cycle still counts as success.
          if (conv_done) begin
            out_gray  <= conv_gray;
            out_valid <= 1'b1;
            state_q   <= StPresent;
          end else if (timer_q == TimerLast) begin
            timeout_err <= 1'b1;
            conv_clear  <= 1'b0;
            state_q     <= StRecover;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StPresent: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            pix_count  <= pix_count + 1'b1;
            conv_clear <= 1'b0;
            state_q    <= StRecover;
          end
        end
        StRecover: begin
          if (timeout_err || (pix_count == len_q)) begin
            busy       <= 1'b0;
            frame_done <= !timeout_err;
            state_q    <= StIdle;
          end else begin
            in_ready <= 1'b1;
            state_q  <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/gray_conv_sequencer.md
GRAY_CONV_SEQUENCER -- requirements
Module: gray_conv_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, maximum number of WAIT cycles allowed for CONV_DONE before aborting the pixel.
REQ-002 Parameter: LEN_W, 16, width of the frame length field and the pixel counter.
REQ-003 Port: CLK  input  1  single clock; all flops rising-edge.
REQ-004 Port: CLEAR  input  1  asynchronous active-low reset.
REQ-005 Port: FRAME_GO  input  1  one-cycle frame start request.
REQ-006 Port: FRAME_PIXELS  input  LEN_W  pixel count, sampled on an accepted FRAME_GO.
REQ-007 Port: IN_VALID / IN_READY  input / output  1 / 1  source RGB handshake.
REQ-008 Port: IN_RGB  input  24  pixel, {R,G,B}.
REQ-009 Port: OUT_VALID / OUT_READY  output / input  1 / 1  sink gray handshake.
REQ-010 Port: OUT_GRAY  output  8  converted pixel.
REQ-011 Port: CONV_START  output  1  one-cycle start pulse to the converter.
REQ-012 Port: CONV_RGB  output  24  converter operand.
REQ-013 Port: CONV_CLEAR  output  1  active-low clear to the converter.
REQ-014 Port: CONV_DONE / CONV_GRAY  input / input  1 / 8  converter completion flag and result.
REQ-015 Port: BUSY  output  1  high in every state except IDLE.
REQ-016 Port: FRAME_DONE  output  1  one-cycle pulse when a frame completes normally.
REQ-017 Port: PIX_COUNT  output  LEN_W  pixels delivered in the current or last frame.
REQ-018 Port: TIMEOUT_ERR  output  1  sticky converter-timeout flag.

Function
REQ-019 The FSM SHALL have these states: IDLE, FETCH, ISSUE, WAIT, PRESENT, RECOVER.
REQ-020 IDLE behaviour:
- FRAME_GO with FRAME_PIXELS!=0 latches the length, clears PIX_COUNT and TIMEOUT_ERR, and moves to FETCH.
- FRAME_GO with FRAME_PIXELS==0 pulses FRAME_DONE on the next cycle and stays in IDLE.
REQ-021 FRAME_GO SHALL be ignored outside IDLE.
REQ-022 IN_READY SHALL be high only in FETCH.
- On IN_VALID&IN_READY, IN_RGB is registered onto CONV_RGB and the FSM moves to ISSUE.
- CONV_RGB holds its value until the next accept.
REQ-023 ISSUE SHALL drive CONV_START=1 for exactly one cycle, then move to WAIT (accept at cycle t gives CONV_START at t+1).
REQ-024 WAIT timer behaviour:
- The timer clears on WAIT entry and increments each WAIT cycle.
- CONV_DONE=1 registers CONV_GRAY onto OUT_GRAY and moves to PRESENT, so OUT_VALID rises the cycle after DONE is sampled.
REQ-025 If WAIT has lasted TIMEOUT_CYCLES cycles with no CONV_DONE, the block SHALL set TIMEOUT_ERR, discard the pixel and move to RECOVER.
- CONV_DONE sampled on the expiry cycle wins, with no error.
REQ-026 CONV_DONE SHALL be ignored in every state except WAIT.
REQ-027 PRESENT behaviour:
- OUT_VALID=1 and OUT_GRAY holds stable until OUT_READY.
- On OUT_VALID&OUT_READY, PIX_COUNT increments (wraps at 2^LEN_W) and the FSM moves to RECOVER.
REQ-028 RECOVER SHALL drive CONV_CLEAR=0 for exactly one cycle, then choose the next state:
- TIMEOUT_ERR set: go to IDLE with no FRAME_DONE.
- PIX_COUNT equals the latched length: go to IDLE and pulse FRAME_DONE in the same cycle IDLE is entered.
- Otherwise: go to FETCH.
REQ-029 CONV_CLEAR SHALL be 1 in every state other than RECOVER once out of reset.
REQ-030 At most one pixel SHALL be in flight; the block has no buffering beyond the CONV_RGB and OUT_GRAY registers.
REQ-031 PIX_COUNT and TIMEOUT_ERR SHALL hold their values in IDLE until the next accepted FRAME_GO.

Reset
REQ-032 CLEAR=0 SHALL asynchronously force the following, from any state including mid-pixel:
- State: IDLE.
- Zero: IN_READY, OUT_VALID, OUT_GRAY, CONV_START, CONV_RGB, BUSY, FRAME_DONE, PIX_COUNT, TIMEOUT_ERR, timer.
- CONV_CLEAR=0.
REQ-033 After CLEAR deasserts, CONV_CLEAR SHALL rise to 1 at the first CLK edge and the block SHALL accept FRAME_GO from that cycle onward.

Verification
REQ-034 Single pixel:
- Stimulus: FRAME_PIXELS=1, IN_RGB=24'hFF0000, model DONE after 3 cycles with GRAY=8'h4C, OUT_READY=1.
- Required response: one CONV_START pulse, OUT_GRAY=8'h4C, CONV_CLEAR low 1 cycle, FRAME_DONE pulse, PIX_COUNT=1.
REQ-035 Back-to-back frame with backpressure:
- Stimulus: FRAME_PIXELS=4, OUT_READY low for 5 cycles on pixel 2.
- Required response: OUT_GRAY stable while stalled, IN_READY low throughout the stall, 4 outputs in order, PIX_COUNT=4.
REQ-036 Timeout:
- Stimulus: model never asserts DONE, TIMEOUT_CYCLES=64.
- Required response: TIMEOUT_ERR=1 after 64 WAIT cycles, no OUT_VALID, no FRAME_DONE, BUSY=0 two cycles later.
REQ-037 Timeout boundary:
- Stimulus: DONE sampled exactly on the expiry cycle.
- Required response: pixel delivered, TIMEOUT_ERR=0.
REQ-038 Zero length and ignored request:
- Stimulus: FRAME_PIXELS=0; FRAME_GO pulsed mid-frame.
- Required response: FRAME_DONE next cycle with no handshakes; the mid-frame FRAME_GO has no effect.
REQ-039 Reset mid-WAIT:
- Stimulus: CLEAR=0 during WAIT.
- Required response: all outputs at reset values immediately, CONV_CLEAR=0; a subsequent 2-pixel frame completes normally.
